pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 89 ++++++++
 tb/tb_pc_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with exception/branch redirect and optional return-address stack.
// Define PC_GEN_RAS_EN to build in the return-address stack.
module pc_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int PC_INC = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = ADDR_WIDTH'('h100),
  parameter int RAS_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetchReady,
  input  logic                  excReq,
  input  logic                  brTaken,
  input  logic [ADDR_WIDTH-1:0] brTarget,
  input  logic                  call,
  input  logic                  ret,
  output logic [ADDR_WIDTH-1:0] pcOut,
  output logic                  pcValid,
  output logic                  misalign,
  output logic                  rasErr
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LOW = ADDR_WIDTH'(PC_INC - 1);
  localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(PC_INC);
  logic [0:0] state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, seq_pc, ret_pc;
  logic misalign_q, misalign_d, ras_err_q, ras_err_d;
  logic run, act;
  assign run = state_q == RUN;
  assign act = run & fetchReady & ~excReq;
  assign seq_pc = pc_q + INC;
`ifdef PC_GEN_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);
  logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0] sp_q, sp_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_push, do_pop, pop_hit;
  assign do_pop = act & ret;
  assign do_push = act & call & ~ret;
  assign pop_hit = do_pop & (cnt_q != '0);
  assign ret_pc = pop_hit ? ras_q[sp_q - PW'(1)] : seq_pc;
  // sp_q is the next free slot; a push into a full stack overwrites the oldest entry
  always_comb begin
    sp_d = pop_hit ? sp_q - PW'(1) : do_push ? sp_q + PW'(1) : sp_q;
    cnt_d = pop_hit ? cnt_q - 1'b1 : (do_push & cnt_q != FULL) ? cnt_q + 1'b1 : cnt_q;
    ras_err_d = ras_err_q | (do_pop & cnt_q == '0) | (do_push & cnt_q == FULL);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sp_q <= '0;
      cnt_q <= '0;
    end else begin
      sp_q <= sp_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) ras_q[sp_q] <= seq_pc;
`else
  logic unused_call;
  assign unused_call = call;
  assign ret_pc = seq_pc;
  assign ras_err_d = 1'b0;
`endif
  always_comb begin
    state_d = RUN;
    pc_d = !run ? pc_q : excReq ? EXC_VECTOR : brTaken ? brTarget & ~LOW :
           (fetchReady & ret) ? ret_pc : fetchReady ? seq_pc : pc_q;
    misalign_d = run & ~excReq & brTaken & |(brTarget & LOW);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      pc_q <= RESET_VECTOR;
      misalign_q <= 1'b0;
      ras_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      misalign_q <= misalign_d;
      ras_err_q <= ras_err_d;
    end
  assign pcOut = pc_q;
  assign pcValid = run;
  assign misalign = misalign_q;
  assign rasErr = ras_err_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed table plus random stimulus against a behavioural model, 32-bit and 8-bit instances.
module tb_pc_gen;
  logic clk = 0, rst = 0;
  logic fr = 0, exc = 0, br = 0, call_i = 0, ret_i = 0;
  logic [31:0] tgt = '0;
  logic [31:0] pc32;
  logic [7:0] pc8;
  logic v32, v8, mis32, mis8, err32, err8;
  int vectors = 0, fails = 0;

  always #5 clk = ~clk;

  pc_gen dut32 (.clk(clk), .rst(rst), .fetchReady(fr), .excReq(exc), .brTaken(br), .brTarget(tgt),
    .call(call_i), .ret(ret_i), .pcOut(pc32), .pcValid(v32), .misalign(mis32), .rasErr(err32));
  pc_gen #(.ADDR_WIDTH(8), .EXC_VECTOR(8'h80)) dut8 (.clk(clk), .rst(rst), .fetchReady(fr),
    .excReq(exc), .brTaken(br), .brTarget(tgt[7:0]), .call(call_i), .ret(ret_i), .pcOut(pc8),
    .pcValid(v8), .misalign(mis8), .rasErr(err8));

  typedef struct {
    logic fr, exc, br, call, ret;
    logic [31:0] tgt;
    logic [31:0] e32;
    logic [7:0] e8;
    logic emis;
  } vec_t;
  vec_t tbl[11];

  localparam int DEPTH = 4;
  logic [31:0] mask [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] excv [2] = '{32'h100, 32'h80};
  logic [31:0] m_pc [2];
  logic m_err [2];
  logic m_valid, m_mis;
  logic [31:0] stk [2][DEPTH];
  int n [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_mis = 0;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0;
      m_err[k] = 0;
      n[k] = 0;
    end
  endtask

  task automatic model_step(input vec_t v);
    logic [31:0] top, nxt;
    bit have;
    if (!m_valid) begin
      m_valid = 1;
      m_mis = 0;
      return;
    end
    m_mis = v.br & !v.exc & (v.tgt[1:0] != 2'b00);
    for (int k = 0; k < 2; k++) begin
      have = 0;
      top = 0;
`ifdef PC_GEN_RAS_EN
      if (v.fr & !v.exc & v.ret) begin
        if (n[k] > 0) begin
          n[k]--;
          top = stk[k][n[k]];
          have = 1;
        end else m_err[k] = 1;
      end
`endif
      nxt = v.exc ? excv[k] : v.br ? (v.tgt & ~32'h3) : (v.fr & have) ? top :
            v.fr ? m_pc[k] + 4 : m_pc[k];
`ifdef PC_GEN_RAS_EN
      if (v.fr & !v.exc & v.call & !v.ret) begin
        if (n[k] == DEPTH) begin
          for (int i = 0; i < DEPTH - 1; i++) stk[k][i] = stk[k][i+1];
          n[k]--;
          m_err[k] = 1;
        end
        stk[k][n[k]] = (m_pc[k] + 4) & mask[k];
        n[k]++;
      end
`endif
      m_pc[k] = nxt & mask[k];
    end
  endtask

  task automatic check_all();
    chk("pc32", pc32, m_pc[0]);
    chk("pc8", {24'b0, pc8}, m_pc[1]);
    chk("valid32", {31'b0, v32}, {31'b0, m_valid});
    chk("valid8", {31'b0, v8}, {31'b0, m_valid});
    chk("mis32", {31'b0, mis32}, {31'b0, m_mis});
    chk("mis8", {31'b0, mis8}, {31'b0, m_mis});
    chk("err32", {31'b0, err32}, {31'b0, m_err[0]});
    chk("err8", {31'b0, err8}, {31'b0, m_err[1]});
  endtask

  task automatic apply(input vec_t v);
    fr = v.fr; exc = v.exc; br = v.br; call_i = v.call; ret_i = v.ret; tgt = v.tgt;
    @(posedge clk);
    model_step(v);
    #1;
    check_all();
  endtask

  function automatic vec_t mk(input logic f, e, b, c, r, input logic [31:0] t);
    vec_t v;
    v = '{f, e, b, c, r, t, 32'h0, 8'h0, 1'b0};
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    tbl[0]  = '{1, 1, 1, 1, 0, 32'h44, 32'h0,   8'h00, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 32'h0,  32'h4,   8'h04, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 32'h0,  32'h8,   8'h08, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 32'h0,  32'hC,   8'h0C, 0};
    tbl[4]  = '{0, 0, 1, 0, 0, 32'h20, 32'h20,  8'h20, 0};
    tbl[5]  = '{0, 0, 1, 0, 0, 32'h43, 32'h40,  8'h40, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 32'h0,  32'h40,  8'h40, 0};
    tbl[7]  = '{1, 1, 1, 1, 1, 32'h80, 32'h100, 8'h80, 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 32'h0,  32'h104, 8'h84, 0};
    tbl[9]  = '{0, 0, 1, 0, 0, 32'hFC, 32'hFC,  8'hFC, 0};
    tbl[10] = '{1, 0, 0, 0, 0, 32'h0,  32'h100, 8'h00, 0};
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i]);
      chk($sformatf("tbl%0d_pc32", i), pc32, tbl[i].e32);
      chk($sformatf("tbl%0d_pc8", i), {24'b0, pc8}, {24'b0, tbl[i].e8});
      chk($sformatf("tbl%0d_mis", i), {31'b0, mis32}, {31'b0, tbl[i].emis});
    end
`ifdef PC_GEN_RAS_EN
    apply(mk(0, 0, 1, 0, 0, 32'h10));
    apply(mk(1, 0, 0, 1, 0, 32'h0));
    apply(mk(0, 0, 1, 0, 0, 32'h200));
    apply(mk(1, 0, 0, 0, 1, 32'h0));
    chk("ras_ret_pc", pc32, 32'h14);
    apply(mk(1, 0, 0, 0, 1, 32'h0));
    chk("ras_underflow_pc", pc32, 32'h18);
    chk("ras_underflow_err", {31'b0, err32}, 32'h1);
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 32'h0));
    for (int i = 0; i < 5; i++) apply(mk(1, 0, 0, 1, 0, 32'h0));
    for (int i = 0; i < 4; i++) apply(mk(1, 0, 0, 0, 1, 32'h0));
    chk("ras_overflow_pc", pc32, 32'h8);
    chk("ras_overflow_err", {31'b0, err32}, 32'h1);
`endif
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 32'h0));
    apply(mk(1, 0, 0, 1, 0, 32'h0));
    apply(mk(1, 0, 0, 1, 0, 32'h0));
    #3 rst = 0;
    model_reset();
    #1;
    chk("async_rst_pc", pc32, 32'h0);
    chk("async_rst_valid", {31'b0, v32}, 32'h0);
    chk("async_rst_err", {31'b0, err32}, 32'h0);
    check_all();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 400; i++)
      apply(mk($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 6) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
